// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: round-robin front end for a shared pipelined bin2bcd converter.
// Grants one requester per cycle and registers its value toward the converter.
// Tags every issued conversion with the requester id in a pipeline matched to the
// converter latency, then routes each returned BCD result back as a one-cycle pulse.
// Sticky flags report results without a tag and tags that expire without a result.
module bcd_conv_arb #(
  parameter int NREQ     = 4,
  parameter int CONV_LAT = 5,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*11-1:0]   req_bin,
  output logic [NREQ-1:0]      req_rdy,
  input  logic                 issue_en,
  output logic                 cv_bin_vld,
  output logic [10:0]          cv_bin,
  input  logic                 cv_bcd_vld,
  input  logic [16:0]          cv_bcd,
  output logic [NREQ-1:0]      rsp_vld,
  output logic [16:0]          rsp_bcd,
  output logic                 busy,
  output logic                 err_orphan,
  output logic                 err_missing,
  input  logic                 err_clr
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IDW-1:0]                rr_ptr_r;
  logic [IDW-1:0]                ptr_nxt_s;
  logic [IDW-1:0]                gnt_id_s;
  logic                          found_s;
  logic [NREQ-1:0]               grant_s;
  logic [10:0]                   gnt_bin_s;
  logic                          cv_bin_vld_r;
  logic [10:0]                   cv_bin_r;
  logic [IDW-1:0]                issue_id_r;
  logic [CONV_LAT-1:0]           tag_vld_r;
  logic [CONV_LAT-1:0][IDW-1:0]  tag_id_r;
  logic                          last_vld_s;
  logic [IDW-1:0]                last_id_s;
  logic                          set_missing_s;
  logic                          set_orphan_s;
  logic [NREQ-1:0]               rsp_vld_r;
  logic [16:0]                   rsp_bcd_r;
  logic                          err_orphan_r;
  logic                          err_missing_r;

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    int idx_v;
    found_s  = 1'b0;
    gnt_id_s = {IDW{1'b0}};
    idx_v    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % NREQ;
      if (!found_s && rst_n && issue_en && req_vld[idx_v]) begin
        found_s  = 1'b1;
        gnt_id_s = IDW'(idx_v);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // One-hot grant vector, selected value and the pointer that follows a transfer.
  always_comb begin
    grant_s   = {NREQ{1'b0}};
    ptr_nxt_s = rr_ptr_r;
    gnt_bin_s = req_bin[11*int'(gnt_id_s) +: 11];
    if (found_s) begin
      grant_s = ONE_HOT0 << gnt_id_s;
      if (gnt_id_s == IDW'(NREQ-1)) begin
        ptr_nxt_s = {IDW{1'b0}};
      end else begin
        ptr_nxt_s = gnt_id_s + {{(IDW-1){1'b0}}, 1'b1};
      end
    end else begin
      grant_s   = {NREQ{1'b0}};
      ptr_nxt_s = rr_ptr_r;
    end
  end

  // Advance the round-robin pointer and register the issued value and its id.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r     <= {IDW{1'b0}};
      cv_bin_vld_r <= 1'b0;
      cv_bin_r     <= 11'd0;
      issue_id_r   <= {IDW{1'b0}};
    end else begin
      rr_ptr_r     <= ptr_nxt_s;
      cv_bin_vld_r <= found_s;
      cv_bin_r     <= found_s ? gnt_bin_s : 11'd0;
      issue_id_r   <= found_s ? gnt_id_s : {IDW{1'b0}};
    end
  end

  // Tag shift register: last stage lines up with the converter's result valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_r <= {CONV_LAT{1'b0}};
      tag_id_r  <= {(CONV_LAT*IDW){1'b0}};
    end else begin
      tag_vld_r[0] <= cv_bin_vld_r;
      tag_id_r[0]  <= issue_id_r;
      for (int k = 1; k < CONV_LAT; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_id_r[k]  <= tag_id_r[k-1];
      end
    end
  end

  // Classify the current converter output against the expiring tag.
  always_comb begin
    last_vld_s    = tag_vld_r[CONV_LAT-1];
    last_id_s     = tag_id_r[CONV_LAT-1];
    set_missing_s = last_vld_s & ~cv_bcd_vld;
    set_orphan_s  = ~last_vld_s & cv_bcd_vld;
  end

  // Route a matched result back to its requester as a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld_r <= {NREQ{1'b0}};
      rsp_bcd_r <= 17'd0;
    end else if (last_vld_s && cv_bcd_vld) begin
      rsp_vld_r <= ONE_HOT0 << last_id_s;
      rsp_bcd_r <= cv_bcd;
    end else begin
      rsp_vld_r <= {NREQ{1'b0}};
      rsp_bcd_r <= 17'd0;
    end
  end

  // Sticky error flags; a new error event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_orphan_r  <= 1'b0;
      err_missing_r <= 1'b0;
    end else begin
      if (set_orphan_s) begin
        err_orphan_r <= 1'b1;
      end else if (err_clr) begin
        err_orphan_r <= 1'b0;
      end else begin
        err_orphan_r <= err_orphan_r;
      end
      if (set_missing_s) begin
        err_missing_r <= 1'b1;
      end else if (err_clr) begin
        err_missing_r <= 1'b0;
      end else begin
        err_missing_r <= err_missing_r;
      end
    end
  end

  assign req_rdy     = grant_s;
  assign cv_bin_vld  = cv_bin_vld_r;
  assign cv_bin      = cv_bin_r;
  assign rsp_vld     = rsp_vld_r;
  assign rsp_bcd     = rsp_bcd_r;
  assign err_orphan  = err_orphan_r;
  assign err_missing = err_missing_r;
  assign busy        = cv_bin_vld_r | (|tag_vld_r);

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Bench for bcd_conv_arb: behavioral converter pipeline, queue scoreboard on the
// response side, table of single-request vectors and hand-written corner sequences.
module tb_bcd_conv_arb;
  localparam int NREQ     = 4;
  localparam int CONV_LAT = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_vld;
  logic [NREQ*11-1:0]   req_bin;
  logic [NREQ-1:0]      req_rdy;
  logic                 issue_en;
  logic                 cv_bin_vld;
  logic [10:0]          cv_bin;
  logic                 cv_bcd_vld;
  logic [16:0]          cv_bcd;
  logic [NREQ-1:0]      rsp_vld;
  logic [16:0]          rsp_bcd;
  logic                 busy;
  logic                 err_orphan;
  logic                 err_missing;
  logic                 err_clr;

  logic                 inj_vld = 1'b0;
  logic [16:0]          inj_bcd = 17'd0;
  logic                 suppress = 1'b0;
  logic [CONV_LAT-1:0]        m_vld;
  logic [CONV_LAT-1:0][16:0]  m_bcd;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct { int id; logic [10:0] bin; logic [16:0] exp; } vec_t;
  typedef struct { logic [3:0] oh; logic [16:0] bcd; int due; } sb_t;
  vec_t tbl[8];
  sb_t  sb[$];

  bcd_conv_arb #(.NREQ(NREQ), .CONV_LAT(CONV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_bin(req_bin), .req_rdy(req_rdy),
    .issue_en(issue_en), .cv_bin_vld(cv_bin_vld), .cv_bin(cv_bin),
    .cv_bcd_vld(cv_bcd_vld), .cv_bcd(cv_bcd), .rsp_vld(rsp_vld), .rsp_bcd(rsp_bcd),
    .busy(busy), .err_orphan(err_orphan), .err_missing(err_missing), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [16:0] to_bcd(input logic [10:0] b);
    int v;
    v = int'(b);
    return {5'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Converter model: fixed latency, flushed by the shared reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_vld <= '0;
      m_bcd <= '0;
    end else begin
      m_vld[0] <= cv_bin_vld;
      m_bcd[0] <= to_bcd(cv_bin);
      for (int k = 1; k < CONV_LAT; k++) begin
        m_vld[k] <= m_vld[k-1];
        m_bcd[k] <= m_bcd[k-1];
      end
    end
  end

  assign cv_bcd_vld = (m_vld[CONV_LAT-1] & ~suppress) | inj_vld;
  assign cv_bcd     = inj_vld ? inj_bcd : m_bcd[CONV_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on every transfer, pop and compare on every response.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_vld != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {28'd0, rsp_vld}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", {28'd0, rsp_vld}, {28'd0, e.oh});
          chk("rsp_bcd", {15'd0, rsp_bcd}, {15'd0, e.bcd});
          chk("rsp_cycle", cyc, e.due);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_vld[i] && req_rdy[i] && !suppress) begin
          e.oh  = 4'b0001 << i;
          e.bcd = to_bcd(req_bin[i*11 +: 11]);
          e.due = cyc + 7;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    chk("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_single(input int id, input logic [10:0] bin, input logic [16:0] exp,
                           input logic check_issue);
    logic got;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    tick();
    req_bin[id*11 +: 11] = bin;
    req_vld = oh;
    @(negedge clk);
    chk("single_rdy", {28'd0, req_rdy}, {28'd0, oh});
    @(posedge clk);
    #1;
    req_vld = 4'b0000;
    if (check_issue) begin
      @(negedge clk);
      chk("issue_vld", {31'd0, cv_bin_vld}, 32'd1);
      chk("issue_bin", {21'd0, cv_bin}, {21'd0, bin});
    end
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (rsp_vld != 4'b0000) got = 1'b1;
    end
    chk("single_rsp_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("single_rsp_id", {28'd0, rsp_vld}, {28'd0, oh});
      chk("single_rsp_bcd", {15'd0, rsp_bcd}, {15'd0, exp});
      chk("single_busy_after", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2, 11'd2047, 17'h02047};
    tbl[1] = '{0, 11'd0,    17'h00000};
    tbl[2] = '{1, 11'd9,    17'h00009};
    tbl[3] = '{3, 11'd10,   17'h00010};
    tbl[4] = '{0, 11'd999,  17'h00999};
    tbl[5] = '{1, 11'd1234, 17'h01234};
    tbl[6] = '{3, 11'd1000, 17'h01000};
    tbl[7] = '{2, 11'd1999, 17'h01999};

    rst_n = 1'b0; issue_en = 1'b1; req_vld = 4'b1111; req_bin = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {28'd0, req_rdy}, 32'd0);
    chk("rst_cv_vld", {31'd0, cv_bin_vld}, 32'd0);
    chk("rst_cv_bin", {21'd0, cv_bin}, 32'd0);
    chk("rst_rsp_vld", {28'd0, rsp_vld}, 32'd0);
    chk("rst_rsp_bcd", {15'd0, rsp_bcd}, 32'd0);
    chk("rst_orphan", {31'd0, err_orphan}, 32'd0);
    chk("rst_missing", {31'd0, err_missing}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_vld = 4'b0000;

    // Table of single requests, one at a time.
    for (int v = 0; v < 8; v++) do_single(tbl[v].id, tbl[v].bin, tbl[v].exp, v == 0);

    // All four requesting continuously from pointer 0.
    apply_reset();
    req_bin = {11'd999, 11'd10, 11'd9, 11'd0};
    req_vld = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", {28'd0, req_rdy}, {28'd0, 4'b0001 << (k % 4)});
      @(posedge clk);
      #1;
    end
    req_vld = 4'b0000;
    wait_idle();

    // Pointer wrap: move pointer to 3, then requesters 1 and 3.
    apply_reset();
    do_single(2, 11'd100, 17'h00100, 1'b0);
    tick();
    req_bin[1*11 +: 11] = 11'd11;
    req_bin[3*11 +: 11] = 11'd33;
    req_vld = 4'b1010;
    @(negedge clk);
    chk("wrap_grant3", {28'd0, req_rdy}, 32'h8);
    @(posedge clk);
    #1;
    req_vld = 4'b0010;
    @(negedge clk);
    chk("wrap_grant1", {28'd0, req_rdy}, 32'h2);
    @(posedge clk);
    #1;
    req_vld = 4'b0000;
    wait_idle();

    // issue_en dropped with two conversions in flight.
    tick();
    req_bin[0 +: 11] = 11'd321;
    req_bin[11 +: 11] = 11'd654;
    req_vld = 4'b0011;
    tick();
    tick();
    issue_en = 1'b0;
    req_vld = 4'b1111;
    @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk("hold_rdy", {28'd0, req_rdy}, 32'd0);
      @(negedge clk);
    end
    chk("hold_drained", sb.size(), 32'd0);
    chk("hold_busy_low", {31'd0, busy}, 32'd0);
    req_vld = 4'b0000;
    issue_en = 1'b1;

    // Stray converter result, clear, and clear colliding with a new error.
    tick();
    inj_bcd = 17'h00555;
    inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    @(negedge clk);
    chk("orphan_set", {31'd0, err_orphan}, 32'd1);
    chk("orphan_no_rsp", {28'd0, rsp_vld}, 32'd0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("orphan_clr", {31'd0, err_orphan}, 32'd0);
    tick();
    err_clr = 1'b1;
    inj_vld = 1'b1;
    tick();
    err_clr = 1'b0;
    inj_vld = 1'b0;
    @(negedge clk);
    chk("orphan_set_wins", {31'd0, err_orphan}, 32'd1);

    // Converter swallows a result: tag expires without a match.
    suppress = 1'b1;
    tick();
    req_bin[2*11 +: 11] = 11'd5;
    req_vld = 4'b0100;
    tick();
    req_vld = 4'b0000;
    repeat (8) @(negedge clk);
    chk("missing_set", {31'd0, err_missing}, 32'd1);
    suppress = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("missing_clr", {31'd0, err_missing}, 32'd0);
    chk("orphan_clr2", {31'd0, err_orphan}, 32'd0);

    // Reset one cycle after issuing 1234.
    tick();
    req_bin[0 +: 11] = 11'd1234;
    req_vld = 4'b0001;
    tick();
    req_vld = 4'b0000;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_cv_vld", {31'd0, cv_bin_vld}, 32'd0);
    chk("mid_rst_cv_bin", {21'd0, cv_bin}, 32'd0);
    chk("mid_rst_rsp", {28'd0, rsp_vld}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    chk("mid_rst_orphan", {31'd0, err_orphan}, 32'd0);
    do_single(0, 11'd1234, 17'h01234, 1'b1);

    wait_idle();
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
